// File: rtl/half_adder_stage.sv
// Registered bank of WIDTH independent half adders behind a valid/ready handshake.
// A one-entry skid register absorbs the first stalled result so in_ready can be a flop.
module half_adder_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;

  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_c;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_skid_s;
  logic [WIDTH-1:0] r_skid_c;
  logic             r_skid_full;
  logic             r_in_ready;

  logic [WIDTH-1:0] w_s_next;
  logic [WIDTH-1:0] w_c_next;
  logic             w_out_valid_next;
  logic [WIDTH-1:0] w_skid_s_next;
  logic [WIDTH-1:0] w_skid_c_next;
  logic             w_skid_full_next;

  logic             w_in_accept;
  logic             w_out_free;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      assign w_sum[gi]   = a[gi] ^ b[gi];
      assign w_carry[gi] = a[gi] & b[gi];
    end
  endgenerate

  assign w_in_accept = in_valid & r_in_ready;
  // Output register can take a new value when empty or being consumed this edge.
  assign w_out_free  = ~r_out_valid | out_ready;

  always_comb begin
    w_s_next         = r_s;
    w_c_next         = r_c;
    w_out_valid_next = r_out_valid;
    w_skid_s_next    = r_skid_s;
    w_skid_c_next    = r_skid_c;
    w_skid_full_next = r_skid_full;

    if (w_out_free) begin
      if (r_skid_full) begin
        w_s_next         = r_skid_s;
        w_c_next         = r_skid_c;
        w_out_valid_next = 1'b1;
        w_skid_full_next = w_in_accept;
        if (w_in_accept) begin
          w_skid_s_next = w_sum;
          w_skid_c_next = w_carry;
        end
      end else if (w_in_accept) begin
        w_s_next         = w_sum;
        w_c_next         = w_carry;
        w_out_valid_next = 1'b1;
      end else begin
        w_out_valid_next = 1'b0;
      end
    end else if (w_in_accept) begin
      w_skid_s_next    = w_sum;
      w_skid_c_next    = w_carry;
      w_skid_full_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s         <= '0;
      r_c         <= '0;
      r_out_valid <= 1'b0;
      r_skid_s    <= '0;
      r_skid_c    <= '0;
      r_skid_full <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_s         <= w_s_next;
      r_c         <= w_c_next;
      r_out_valid <= w_out_valid_next;
      r_skid_s    <= w_skid_s_next;
      r_skid_c    <= w_skid_c_next;
      r_skid_full <= w_skid_full_next;
      // Kept as the registered complement of skid_full so in_ready has no combinational path.
      r_in_ready  <= ~w_skid_full_next;
    end
  end

  assign s         = r_s;
  assign c         = r_c;
  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;

endmodule

// File: tb/tb_half_adder_stage.sv
// Self-checking bench for half_adder_stage: directed vectors, reset, backpressure,
// random streaming against a scoreboard queue, and an 8-lane instance.
module tb_half_adder_stage;

  logic       clk;
  logic       rst;
  logic [0:0] a, b, s, c;
  logic       in_valid, in_ready, out_valid, out_ready;

  logic [7:0] a8, b8, s8, c8;
  logic       in_valid8, in_ready8, out_valid8, out_ready8;

  int n_checks = 0;
  int n_fail   = 0;
  int n_in     = 0;
  int n_out    = 0;
  logic [1:0] sb_q[$];
  logic [1:0] sb_exp;

  half_adder_stage #(.WIDTH(1)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .c(c), .out_valid(out_valid), .out_ready(out_ready)
  );

  half_adder_stage #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(in_valid8), .in_ready(in_ready8),
    .s(s8), .c(c8), .out_valid(out_valid8), .out_ready(out_ready8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: sampled mid-cycle, so these are the handshakes the next edge will see.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      n_in  = 0;
      n_out = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          sb_exp = sb_q.pop_front();
          check("sb_result", 32'({s, c}), 32'(sb_exp));
          n_out++;
          $display("out #%0d: s=%0b c=%0b", n_out, s, c);
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back({a ^ b, a & b});
        n_in++;
      end
    end
  end

  initial begin
    logic [1:0] v;
    rst = 1'b1;
    a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b1;
    a8 = '0; b8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b1;
    #2;
    check("reset_s", 32'(s), 32'd0);
    check("reset_c", 32'(c), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;

    // Exhaustive vectors: one pair every two cycles, result visible right after acceptance.
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      a = v[1]; b = v[0]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("vec_out_valid", 32'(out_valid), 32'd1);
      check("vec_s", 32'(s), 32'(v[1] ^ v[0]));
      check("vec_c", 32'(c), 32'(v[1] & v[0]));
      tick();
      check("vec_out_valid_clear", 32'(out_valid), 32'd0);
    end

    // Full-rate streaming: in_ready never drops, no bubbles on the output.
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 1'($urandom); b = 1'($urandom);
      tick();
      check("stream_in_ready", 32'(in_ready), 32'd1);
      check("stream_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();

    // Reset in the middle of a held result.
    out_ready = 1'b0;
    a = 1'b1; b = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_s", 32'(s), 32'd0);
    check("async_reset_c", 32'(c), 32'd0);
    check("async_reset_out_valid", 32'(out_valid), 32'd0);
    check("async_reset_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Backpressure: pair1 -> output, pair2 -> skid, pair3 held off.
    out_ready = 1'b0;
    a = 1'b1; b = 1'b1; in_valid = 1'b1;
    tick();
    check("bp_first_s", 32'(s), 32'd0);
    check("bp_first_c", 32'(c), 32'd1);
    check("bp_first_in_ready", 32'(in_ready), 32'd1);
    a = 1'b0; b = 1'b1;
    tick();
    check("bp_skid_in_ready", 32'(in_ready), 32'd0);
    a = 1'b0; b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_s", 32'(s), 32'd0);
      check("bp_hold_c", 32'(c), 32'd1);
      check("bp_hold_out_valid", 32'(out_valid), 32'd1);
    end
    // Drain with skid full and in_valid high: skid moves up, skid frees.
    out_ready = 1'b1;
    tick();
    check("drain_skid_s", 32'(s), 32'd1);
    check("drain_skid_c", 32'(c), 32'd0);
    check("drain_skid_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("drain_third_s", 32'(s), 32'd0);
    check("drain_third_c", 32'(c), 32'd0);
    check("drain_third_valid", 32'(out_valid), 32'd1);
    tick();
    check("bp_count", 32'(n_out), 32'(n_in));

    // Random streaming with random backpressure.
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom);
      a         = 1'($urandom);
      b         = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    check("rand_leftover", 32'(sb_q.size()), 32'd0);
    check("rand_count", 32'(n_out), 32'(n_in));
    check("rand_idle_in_ready", 32'(in_ready), 32'd1);

    // Eight independent lanes.
    a8 = 8'hF0; b8 = 8'hCC; in_valid8 = 1'b1;
    tick();
    check("lane8_s0", 32'(s8), 32'h3C);
    check("lane8_c0", 32'(c8), 32'hC0);
    check("lane8_v0", 32'(out_valid8), 32'd1);
    a8 = 8'hFF; b8 = 8'hFF;
    tick();
    in_valid8 = 1'b0;
    check("lane8_s1", 32'(s8), 32'h00);
    check("lane8_c1", 32'(c8), 32'hFF);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
